// File: rtl/sv39_tlb.sv
// Fully-associative Sv39 TLB in front of the page-table walker.
// Caches 4KB/2MB/1GB leaves; hits answer in one cycle, misses walk then refill.
module sv39_tlb #(
    parameter int ENTRIES = 8,
    parameter int IDX_W   = 3
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_flush,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [63:0] i_req_vaddr,
    output logic        o_resp_valid,
    output logic [63:0] o_resp_paddr,
    output logic        o_resp_fault,
    output logic        o_ptw_req_valid,
    input  logic        i_ptw_req_ready,
    output logic [26:0] o_ptw_req_vpn,
    input  logic        i_ptw_resp_valid,
    input  logic [43:0] i_ptw_resp_ppn,
    input  logic [1:0]  i_ptw_resp_level,
    input  logic        i_ptw_resp_fault
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WREQ  = 2'd1,
        S_WRESP = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ENTRIES-1:0] r_valid;
    logic [26:0]        r_vpn [ENTRIES];
    logic [43:0]        r_ppn [ENTRIES];
    logic [1:0]         r_lvl [ENTRIES];
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [26:0]        r_ptw_vpn;
    logic [29:0]        r_vaddr_lo;
    logic [43:0]        r_w_ppn;
    logic [1:0]         r_w_lvl;
    logic               r_w_fault;
    logic               r_drop;
    logic               r_resp_valid;
    logic [63:0]        r_resp_paddr;
    logic               r_resp_fault;

    logic               w_accept;
    logic               w_hit;
    logic [63:0]        w_hit_paddr;
    logic               w_has_inv;
    logic [IDX_W-1:0]   w_inv_idx;
    logic [IDX_W-1:0]   w_victim;
    logic               w_walk_fault;
    logic               w_refill;
    logic               w_unused;

    // Level 0 = 1GB, 1 = 2MB, 2 = 4KB; level 3 is never stored.
    function automatic logic f_match(input logic [26:0] e_vpn, input logic [1:0] lvl,
                                     input logic [26:0] vpn);
        logic m;
        case (lvl)
            2'd0:    m = (e_vpn[26:18] == vpn[26:18]);
            2'd1:    m = (e_vpn[26:9] == vpn[26:9]);
            2'd2:    m = (e_vpn == vpn);
            default: m = 1'b0;
        endcase
        return m;
    endfunction

    function automatic logic [63:0] f_paddr(input logic [43:0] ppn, input logic [1:0] lvl,
                                            input logic [29:0] va);
        logic [63:0] pa;
        case (lvl)
            2'd0:    pa = {8'd0, ppn[43:18], va[29:0]};
            2'd1:    pa = {8'd0, ppn[43:9], va[20:0]};
            2'd2:    pa = {8'd0, ppn, va[11:0]};
            default: pa = 64'd0;
        endcase
        return pa;
    endfunction

    assign w_unused        = ^i_req_vaddr[63:39];
    assign o_req_ready     = i_rst_n && (r_state == S_IDLE) && !i_flush;
    assign w_accept        = o_req_ready && i_req_valid;
    assign o_ptw_req_valid = (r_state == S_WREQ);
    assign o_ptw_req_vpn   = r_ptw_vpn;
    assign o_resp_valid    = r_resp_valid;
    assign o_resp_paddr    = r_resp_paddr;
    assign o_resp_fault    = r_resp_fault;
    assign w_walk_fault    = r_w_fault || (r_w_lvl == 2'd3);
    assign w_refill        = (r_state == S_RESP) && !w_walk_fault && !r_drop && !i_flush;
    assign w_victim        = w_has_inv ? w_inv_idx : r_rr_ptr;

    // Associative lookup; at most one entry matches, so the results can be OR-combined.
    always_comb begin
        w_hit       = 1'b0;
        w_hit_paddr = 64'd0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (r_valid[i] && f_match(r_vpn[i], r_lvl[i], i_req_vaddr[38:12])) begin
                w_hit       = 1'b1;
                w_hit_paddr = w_hit_paddr | f_paddr(r_ppn[i], r_lvl[i], i_req_vaddr[29:0]);
            end else begin
                w_hit_paddr = w_hit_paddr;
            end
        end
    end

    // Lowest-index invalid slot (scan downwards so the lowest index wins).
    always_comb begin
        w_has_inv = 1'b0;
        w_inv_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!r_valid[i]) begin
                w_has_inv = 1'b1;
                w_inv_idx = IDX_W'(i);
            end else begin
                w_inv_idx = w_inv_idx;
            end
        end
    end

    // Next-state logic for the miss/walk sequencer.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && !w_hit) w_state_nxt = S_WREQ;
                else                    w_state_nxt = S_IDLE;
            end
            S_WREQ: begin
                if (i_ptw_req_ready) w_state_nxt = S_WRESP;
                else                 w_state_nxt = S_WREQ;
            end
            S_WRESP: begin
                if (i_ptw_resp_valid) w_state_nxt = S_RESP;
                else                  w_state_nxt = S_WRESP;
            end
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Control state, response registers, valid bits and replacement pointer.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_valid      <= '0;
            r_rr_ptr     <= '0;
            r_ptw_vpn    <= 27'd0;
            r_vaddr_lo   <= 30'd0;
            r_w_ppn      <= 44'd0;
            r_w_lvl      <= 2'd0;
            r_w_fault    <= 1'b0;
            r_drop       <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_paddr <= 64'd0;
            r_resp_fault <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_resp_valid <= 1'b0;
            if (w_accept && w_hit) begin
                r_resp_valid <= 1'b1;
                r_resp_paddr <= w_hit_paddr;
                r_resp_fault <= 1'b0;
            end else if (r_state == S_RESP) begin
                r_resp_valid <= 1'b1;
                r_resp_paddr <= w_walk_fault ? 64'd0 : f_paddr(r_w_ppn, r_w_lvl, r_vaddr_lo);
                r_resp_fault <= w_walk_fault;
            end
            if (w_accept && !w_hit) begin
                r_ptw_vpn  <= i_req_vaddr[38:12];
                r_vaddr_lo <= i_req_vaddr[29:0];
            end
            if ((r_state == S_WRESP) && i_ptw_resp_valid) begin
                r_w_ppn   <= i_ptw_resp_ppn;
                r_w_lvl   <= i_ptw_resp_level;
                r_w_fault <= i_ptw_resp_fault;
            end
            // A flush seen anywhere during a walk makes that walk's result uncacheable.
            if (r_state == S_IDLE) r_drop <= 1'b0;
            else if (i_flush)      r_drop <= 1'b1;
            if (i_flush)       r_valid <= '0;
            else if (w_refill) r_valid[w_victim] <= 1'b1;
            if (w_refill && !w_has_inv) r_rr_ptr <= r_rr_ptr + IDX_W'(1);
        end
    end

    // Entry payload; only meaningful where the matching valid bit is set.
    always_ff @(posedge i_clk) begin
        if (w_refill) begin
            r_vpn[w_victim] <= r_ptw_vpn;
            r_ppn[w_victim] <= r_w_ppn;
            r_lvl[w_victim] <= r_w_lvl;
        end
    end

endmodule
